parking_occupancy_ctrl: RTL

- Counts vehicles in a lot of CAPACITY spaces from entry and exit sensor inputs.
- Drives a two-digit, time-multiplexed 7-segment display through the team's 4-bit-code segment decoder, which sits directly downstream.
- Shows the occupancy count on digit 0 and blanks digit 1. When the lot is full, shows the letters "LO" (lotado).
- Each sensor input is synchronised and debounced, then edge-detected to give exactly one count event per vehicle.

---
 rtl/parking_occupancy_ctrl_pkg.sv | 15 +
 rtl/sensor_debouncer.sv | 50 +++++
 rtl/parking_occupancy_ctrl.sv | 118 +++++++++++
 3 files changed

// File: rtl/parking_occupancy_ctrl_pkg.sv
// Shared constants for the parking occupancy controller: display codes
// understood by the downstream segment decoder, digit-select patterns and
// the default lot capacity.
package parking_pkg;

   localparam logic [3:0] CODE_L       = 4'hA;
   localparam logic [3:0] CODE_O       = 4'hB;
   localparam logic [3:0] CODE_BLANK   = 4'hF;

   localparam logic [1:0] DIGSEL_UNITS = 2'b10;
   localparam logic [1:0] DIGSEL_TENS  = 2'b01;

   localparam int DEFAULT_CAPACITY     = 8;

endpackage : parking_pkg

// File: rtl/sensor_debouncer.sv
// Sensor input conditioning: two-flop synchroniser, stability-counter
// debouncer and a one-cycle rising-edge pulse on the debounced level.
module sensor_debouncer #(
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic level,
   output logic rise_pulse
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             r_sync1;
   logic             r_sync2;
   logic             r_level;
   logic             r_level_d;
   logic [CNT_W-1:0] r_cnt;

   // Synchronise the raw input, then accept a new level only after it has
   // differed from the current debounced level for DEBOUNCE_CYCLES cycles.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1   <= 1'b0;
         r_sync2   <= 1'b0;
         r_level   <= 1'b0;
         r_level_d <= 1'b0;
         r_cnt     <= '0;
      end else begin
         r_sync1   <= raw;
         r_sync2   <= r_sync1;
         r_level_d <= r_level;
         if (r_sync2 == r_level) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_MAX) begin
            r_level <= r_sync2;
            r_cnt   <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign level      = r_level;
   // High only in the cycle right after the debounced level rises.
   assign rise_pulse = r_level & ~r_level_d;

endmodule : sensor_debouncer

// File: rtl/parking_occupancy_ctrl.sv
// Parking lot occupancy counter with a two-digit multiplexed display.
// Digit 0 shows the count (digit 1 blank); a full lot shows "LO".
module parking_occupancy_ctrl
   import parking_pkg::*;
#(
   parameter int CAPACITY        = DEFAULT_CAPACITY,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int SCAN_DIV        = 50000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       entry_sensor,
   input  logic       exit_sensor,
   output logic [3:0] digit_code,
   output logic [1:0] digit_sel,
   output logic [3:0] count,
   output logic       full,
   output logic       empty,
   output logic       entry_rejected
);

   localparam logic [3:0] CAP = 4'(CAPACITY);
   localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [SCAN_W-1:0] SCAN_MAX = SCAN_W'(SCAN_DIV - 1);

   logic              w_entry_rise;
   logic              w_exit_rise;
   logic              w_entry_level;
   logic              w_exit_level;
   logic [1:0]        w_unused_levels;

   logic [3:0]        r_count;
   logic              r_full;
   logic              r_empty;
   logic [3:0]        w_count_nxt;
   logic              w_reject;

   logic [SCAN_W-1:0] r_scan;
   logic [1:0]        r_digsel;
   logic [3:0]        r_code;
   logic              w_scan_wrap;
   logic [1:0]        w_digsel_nxt;
   logic [3:0]        w_code_nxt;

   sensor_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_entry (
      .clk        (clk),
      .reset      (reset),
      .raw        (entry_sensor),
      .level      (w_entry_level),
      .rise_pulse (w_entry_rise)
   );

   sensor_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_exit (
      .clk        (clk),
      .reset      (reset),
      .raw        (exit_sensor),
      .level      (w_exit_level),
      .rise_pulse (w_exit_rise)
   );

   // Debounced levels are not needed here; only the rise events count.
   assign w_unused_levels = {w_entry_level, w_exit_level};

   // Next occupancy from the event pair; simultaneous events cancel out.
   always_comb begin
      w_count_nxt = r_count;
      w_reject    = 1'b0;
      if (w_entry_rise && !w_exit_rise) begin
         if (r_count == CAP) w_reject    = 1'b1;
         else                w_count_nxt = r_count + 4'd1;
      end else if (!w_entry_rise && w_exit_rise) begin
         if (r_count != 4'd0) w_count_nxt = r_count - 4'd1;
      end
   end

   // Occupancy register with full/empty flags kept in step with it.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_count <= 4'd0;
         r_full  <= 1'b0;
         r_empty <= 1'b1;
      end else begin
         r_count <= w_count_nxt;
         r_full  <= (w_count_nxt == CAP);
         r_empty <= (w_count_nxt == 4'd0);
      end
   end

   // Next digit select and the code it should display, from current count.
   always_comb begin
      w_scan_wrap  = (r_scan == SCAN_MAX);
      w_digsel_nxt = w_scan_wrap ? ~r_digsel : r_digsel;
      w_code_nxt   = r_count;
      if (w_digsel_nxt == DIGSEL_TENS) w_code_nxt = r_full ? CODE_L : CODE_BLANK;
      else                             w_code_nxt = r_full ? CODE_O : r_count;
   end

   // Scan counter, digit select and digit code advance together.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_scan   <= '0;
         r_digsel <= DIGSEL_UNITS;
         r_code   <= 4'h0;
      end else begin
         r_scan   <= w_scan_wrap ? '0 : r_scan + 1'b1;
         r_digsel <= w_digsel_nxt;
         r_code   <= w_code_nxt;
      end
   end

   assign count          = r_count;
   assign full           = r_full;
   assign empty          = r_empty;
   assign entry_rejected = w_reject;
   assign digit_sel      = r_digsel;
   assign digit_code     = r_code;

endmodule : parking_occupancy_ctrl
